// File: rtl/wptr_full_ctrl.sv
// ============================================================================
// wptr_full_ctrl: write-side binary/Gray pointer, full, almost-full, level
// and (with WPTR_OVF_FLAG_EN) sticky overflow flag for a dual-clock FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AFULL_T = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_pattern;
  logic              wen;
  logic              full_next;
  logic              afull_next;

  // The registered wfull gates acceptance, so a write at the full boundary
  // is dropped even if the read pointer advances in the same cycle.
  assign wen       = winc & ~wfull;
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  // Full when the Gray pointers differ only in their two MSBs.
  assign full_pattern = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  assign full_next    = (wgraynext == full_pattern);
  assign level_next   = wbinnext - rbin_s;
  assign afull_next   = (level_next >= AFULL_T);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

`ifdef WPTR_OVF_FLAG_EN
  logic ovf_q;

  // A new violation takes priority over a clear in the same cycle.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_q <= 1'b0;
    end else if (winc & wfull) begin
      ovf_q <= 1'b1;
    end else if (wovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign woverflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = wovf_clr;
  assign woverflow      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
// tb_wptr_full_ctrl: scoreboard bench; expected values come from a
// write/read-count model of the FIFO, checked by a separate monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wptr_full_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = DEPTH - 2;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          winc = 1'b0;
  logic [AW:0]   wq2_rptr = '0;
  logic          wovf_clr = 1'b0;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          woverflow;

  wptr_full_ctrl #(.ADDRSIZE(AW), .AFULL_THRESH(THR)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .waddr(waddr), .wptr(wptr), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic          full;
    logic          afull;
    logic [AW:0]   level;
    logic [AW-1:0] addr;
    logic [AW:0]   ptr;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: total accepted writes and total reads seen through wq2_rptr.
  int   m_w    = 0;
  int   m_r    = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_model();
    exp_t e;
    int   lvl;
    lvl     = m_w - m_r;
    e.full  = (lvl == DEPTH);
    e.afull = (lvl >= THR);
    e.level = lvl[AW:0];
    e.addr  = m_w[AW-1:0];
    e.ptr   = gray(m_w);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic inc, input int radv, input logic clr);
    @(negedge wclk);
    winc     = inc;
    wovf_clr = clr;
    m_r      = m_r + radv;
    if (m_r > m_w) m_r = m_w;
    wq2_rptr = gray(m_r);
`ifdef WPTR_OVF_FLAG_EN
    if (inc && m_full) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
`endif
    if (inc && !m_full) m_w = m_w + 1;
    m_full = ((m_w - m_r) == DEPTH);
    push_model();
  endtask

  task automatic do_reset();
    @(negedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_wfull", {31'b0, wfull}, 0);
    chk("rst_afull", {31'b0, walmost_full}, 0);
    chk("rst_wlevel", {27'b0, wlevel}, 0);
    chk("rst_waddr", {28'b0, waddr}, 0);
    chk("rst_wptr", {27'b0, wptr}, 0);
    chk("rst_wovf", {31'b0, woverflow}, 0);
    m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
    winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
    repeat (2) begin
      @(negedge wclk);
      push_model();
    end
    #2 wrst_n = 1'b1;
  endtask

  // Monitor: every edge that has a pending expectation is checked.
  initial begin
    forever begin
      @(posedge wclk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wfull", {31'b0, wfull}, {31'b0, e.full});
        chk("walmost_full", {31'b0, walmost_full}, {31'b0, e.afull});
        chk("wlevel", {27'b0, wlevel}, {27'b0, e.level});
        chk("waddr", {28'b0, waddr}, {28'b0, e.addr});
        chk("wptr", {27'b0, wptr}, {27'b0, e.ptr});
        chk("woverflow", {31'b0, woverflow}, {31'b0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge wclk);
    do_reset();

    // Fill, overflow attempts, sticky flag, clear.
    repeat (DEPTH) step(1'b1, 0, 1'b0);
    repeat (3) step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // Drain release, then boundary race at full (write dropped).
    step(1'b0, 1, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b0, 0, 1'b0);

    // Wrap with the read pointer tracking closely.
    do_reset();
    for (int i = 0; i < 2 * DEPTH + 4; i++) step(1'b1, (i > 0) ? 1 : 0, 1'b0);

    // Race at 15 entries: write accepted alongside a read.
    do_reset();
    repeat (DEPTH - 1) step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, 2)), ($urandom % 8) == 0);
    end

    do_reset();
    repeat (3) step(1'b1, 0, 1'b0);

    @(posedge wclk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
